// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the SpyBuffer async FIFO: pointers, empty flag, FWFT output register.
// Optional occupancy count and almost-empty flag are built when FIFO_RD_COUNT_EN is defined.
module fifo_rd_ctrl #(
    parameter int unsigned ADDRSIZE      = 4,
    parameter int unsigned DATASIZE      = 32,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rdata_mem,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                ren,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [ADDRSIZE:0]   rcount,
    output logic                raempty
);

    logic [ADDRSIZE:0]   rbin_q, rbin_d;
    logic [ADDRSIZE:0]   rptr_q, rptr_d;
    logic                rempty_q, rempty_d;
    logic [DATASIZE-1:0] dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic [ADDRSIZE:0]   rbinnext;
    logic [ADDRSIZE:0]   rgraynext;

    always_comb begin
        ren       = !rempty_q && (!dout_valid_q || dout_ready);
        rbinnext  = rbin_q + {{ADDRSIZE{1'b0}}, ren};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        rbin_d    = rbinnext;
        rptr_d    = rgraynext;
        rempty_d  = (rgraynext == rq2_wptr);
    end

    // A fetch into the output register takes priority over draining it, so a
    // word can leave and the next arrive on the same edge.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (ren) begin
            dout_d       = rdata_mem;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rempty_q     <= rempty_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

`ifdef FIFO_RD_COUNT_EN
    localparam int unsigned AEMPTY_CLAMP =
        (AEMPTY_THRESH > (2 ** ADDRSIZE)) ? (2 ** ADDRSIZE) : AEMPTY_THRESH;
    localparam logic [ADDRSIZE:0] AEMPTY_LIM = (ADDRSIZE + 1)'(AEMPTY_CLAMP);

    logic [ADDRSIZE:0] rq2_wbin;
    logic [ADDRSIZE:0] rcount_q, rcount_d;
    logic              raempty_q, raempty_d;

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    always_comb begin
        rq2_wbin = '0;
        for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
            rq2_wbin[i] = ^(rq2_wptr >> i);
        end
        rcount_d  = rq2_wbin - rbinnext;
        raempty_d = (rcount_d <= AEMPTY_LIM);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rcount_q  <= '0;
            raempty_q <= 1'b1;
        end else begin
            rcount_q  <= rcount_d;
            raempty_q <= raempty_d;
        end
    end

    assign rcount  = rcount_q;
    assign raempty = raempty_q;
`else
    // With no count the RAM always reads as holding zero words.
    localparam logic RAEMPTY_IDLE = (AEMPTY_THRESH >= 0);

    assign rcount  = '0;
    assign raempty = RAEMPTY_IDLE;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl (ADDRSIZE=4, DATASIZE=32, AEMPTY_THRESH=2).
module tb_fifo_rd_ctrl;

    logic        rclk;
    logic        rrst_n;
    logic [4:0]  rq2_wptr;
    logic [31:0] rdata_mem;
    logic [3:0]  raddr;
    logic        ren;
    logic [4:0]  rptr;
    logic        rempty;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [4:0]  rcount;
    logic        raempty;

    int checks = 0;
    int errors = 0;

    fifo_rd_ctrl #(
        .ADDRSIZE(4),
        .DATASIZE(32),
        .AEMPTY_THRESH(2)
    ) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .rq2_wptr(rq2_wptr),
        .rdata_mem(rdata_mem),
        .raddr(raddr),
        .ren(ren),
        .rptr(rptr),
        .rempty(rempty),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .rcount(rcount),
        .raempty(raempty)
    );

    // RAM image: word at address a is 0xA5A5_0001 + a
    assign rdata_mem = 32'hA5A5_0001 + {28'b0, raddr};

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int unsigned exp);
`ifdef FIFO_RD_COUNT_EN
        check({tag, "_rcount"}, 64'(rcount), 64'(exp));
        check({tag, "_raempty"}, 64'(raempty), 64'(exp <= 2));
`else
        check({tag, "_rcount"}, 64'(rcount), 64'd0);
        check({tag, "_raempty"}, 64'(raempty), 64'd1);
`endif
    endtask

    function automatic logic [4:0] gray(input int unsigned b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rq2_wptr   = 5'd0;
        rrst_n     = 1'b0;
        #3;
        rrst_n     = 1'b1;
        tick();
    endtask

    initial begin
        int unsigned n;
        int unsigned wb;
        int unsigned budget;

        // ---------------- reset values, before any clock edge
        rrst_n     = 1'b1;
        rq2_wptr   = 5'($urandom);
        dout_ready = 1'($urandom);
        #2;
        rrst_n = 1'b0;
        #1;
        check("rst_rptr", 64'(rptr), 64'd0);
        check("rst_rempty", 64'(rempty), 64'd1);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_ren", 64'(ren), 64'd0);
        check("rst_raddr", 64'(raddr), 64'd0);
        check_cnt("rst", 0);
        tick();
        tick();
        rq2_wptr   = 5'd0;
        dout_ready = 1'b0;
        #3;
        rrst_n = 1'b1;
        tick();
        tick();
        tick();
        check("idle_rempty", 64'(rempty), 64'd1);
        check("idle_valid", 64'(dout_valid), 64'd0);
        check("idle_rptr", 64'(rptr), 64'd0);
        check("idle_ren", 64'(ren), 64'd0);

        // ---------------- single word
        rq2_wptr   = 5'b00001;
        dout_ready = 1'b1;
        #1;
        check("sw_ren_pre", 64'(ren), 64'd0);
        tick();
        check("sw_rempty_fall", 64'(rempty), 64'd0);
        check("sw_ren", 64'(ren), 64'd1);
        check("sw_raddr", 64'(raddr), 64'd0);
        check_cnt("sw_fall", 1);
        tick();
        check("sw_dout", 64'(dout), 64'hA5A5_0001);
        check("sw_valid", 64'(dout_valid), 64'd1);
        check("sw_rptr", 64'(rptr), 64'b00001);
        check("sw_rempty_rise", 64'(rempty), 64'd1);
        check("sw_ren_off", 64'(ren), 64'd0);
        check_cnt("sw_load", 0);
        tick();
        check("sw_valid_drop", 64'(dout_valid), 64'd0);
        check("sw_dout_hold", 64'(dout), 64'hA5A5_0001);

        // ---------------- full drain of 16 words
        do_reset();
        rq2_wptr   = 5'b11000;
        dout_ready = 1'b1;
        tick();
        check("fd_rempty_fall", 64'(rempty), 64'd0);
        check_cnt("fd_fall", 16);
        for (int unsigned i = 0; i < 16; i++) begin
            tick();
            check($sformatf("fd_dout_%0d", i), 64'(dout), 64'(32'hA5A5_0001 + i));
            check($sformatf("fd_valid_%0d", i), 64'(dout_valid), 64'd1);
            check($sformatf("fd_rptr_%0d", i), 64'(rptr), 64'(gray(i + 1)));
            check($sformatf("fd_rempty_%0d", i), 64'(rempty), 64'(i == 15));
            check_cnt($sformatf("fd_%0d", i), 15 - i);
        end
        tick();
        check("fd_end_valid", 64'(dout_valid), 64'd0);
        check("fd_end_rptr", 64'(rptr), 64'b11000);
        check("fd_end_rempty", 64'(rempty), 64'd1);

        // ---------------- backpressure, 4 words available
        do_reset();
        rq2_wptr   = gray(4);
        dout_ready = 1'b0;
        tick();
        check("bp_rempty_fall", 64'(rempty), 64'd0);
        tick();
        check("bp_dout0", 64'(dout), 64'hA5A5_0001);
        check("bp_valid0", 64'(dout_valid), 64'd1);
        check("bp_rptr0", 64'(rptr), 64'b00001);
        check_cnt("bp_load0", 3);
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_dout_%0d", i), 64'(dout), 64'hA5A5_0001);
            check($sformatf("bp_hold_valid_%0d", i), 64'(dout_valid), 64'd1);
            check($sformatf("bp_hold_ren_%0d", i), 64'(ren), 64'd0);
            check($sformatf("bp_hold_rptr_%0d", i), 64'(rptr), 64'b00001);
        end
        dout_ready = 1'b1;
        #1;
        check("bp_ren_resume", 64'(ren), 64'd1);
        for (int unsigned i = 1; i < 4; i++) begin
            tick();
            check($sformatf("bp_dout_%0d", i), 64'(dout), 64'(32'hA5A5_0001 + i));
            check($sformatf("bp_valid_%0d", i), 64'(dout_valid), 64'd1);
            check($sformatf("bp_rptr_%0d", i), 64'(rptr), 64'(gray(i + 1)));
            check_cnt($sformatf("bp_%0d", i), 3 - i);
        end
        check("bp_rempty_end", 64'(rempty), 64'd1);
        tick();
        check("bp_valid_end", 64'(dout_valid), 64'd0);

        // ---------------- wrap: 40 words in bursts of 10
        do_reset();
        dout_ready = 1'b1;
        n = 0;
        for (int unsigned b = 0; b < 4; b++) begin
            wb       = 10 * (b + 1);
            rq2_wptr = gray(wb);
            budget   = 0;
            while (budget < 20) begin
                tick();
                budget++;
                if (dout_valid) begin
                    check($sformatf("wr_dout_%0d", n), 64'(dout), 64'(32'hA5A5_0001 + (n % 16)));
                    check($sformatf("wr_rptr_%0d", n), 64'(rptr), 64'(gray(n + 1)));
                    check($sformatf("wr_msb_%0d", n), 64'(rptr[4]), 64'(((n + 1) / 16) % 2));
                    check_cnt($sformatf("wr_%0d", n), wb - (n + 1));
                    n++;
                end
            end
            check($sformatf("wr_burst_words_%0d", b), 64'(n), 64'(wb));
            check($sformatf("wr_burst_rempty_%0d", b), 64'(rempty), 64'd1);
        end

        // ---------------- reset mid-stream with 7 words pending
        do_reset();
        rq2_wptr   = gray(8);
        dout_ready = 1'b1;
        tick();
        tick();
        dout_ready = 1'b0;
        #1;
        check("ms_valid_pre", 64'(dout_valid), 64'd1);
        check("ms_rptr_pre", 64'(rptr), 64'b00001);
        rrst_n = 1'b0;
        #1;
        check("ms_valid", 64'(dout_valid), 64'd0);
        check("ms_rempty", 64'(rempty), 64'd1);
        check("ms_rptr", 64'(rptr), 64'd0);
        check("ms_dout", 64'(dout), 64'd0);
        check("ms_ren", 64'(ren), 64'd0);
        check_cnt("ms", 0);
        #5;
        rrst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
